alarm_clock_ctrl: RTL and testbench

Mode controller and alarm sequencer for the digital alarm clock. It takes single-cycle, already-debounced button pulses and a 1 Hz tick. From these it runs the mode FSM (clock/adjust), issues inc/dec strobes to the time counter, owns the BCD alarm-time register, and raises the alarm on a time match. It sits between the push-button detectors and the time counter / display mux.

---
 rtl/alarm_clock_ctrl.sv | 168 ++++++++++++++++
 tb/tb_alarm_clock_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock_ctrl.sv
// Mode FSM and alarm sequencer for the digital alarm clock: turns button pulses
// into adjust strobes, owns the BCD alarm register and rings on a time match.
module alarm_clock_ctrl #(
  parameter bit BLINK_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_1hz,
  input  logic        btnc,
  input  logic        btnr,
  input  logic        btnl,
  input  logic        btnu,
  input  logic        btnd,
  input  logic [12:0] cur_time,
  output logic        clk_run,
  output logic        min_inc,
  output logic        min_dec,
  output logic        hr_inc,
  output logic        hr_dec,
  output logic [12:0] alarm_time,
  output logic        disp_alarm,
  output logic [3:0]  blink_mask,
  output logic        alarm_en,
  output logic        alarm_active,
  output logic [4:0]  mode_led
);

  typedef enum logic [2:0] {
    S_CLOCK   = 3'd0,
    S_CLK_MIN = 3'd1,
    S_CLK_HR  = 3'd2,
    S_ALM_MIN = 3'd3,
    S_ALM_HR  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [12:0] alarm_time_q, alarm_time_d;
  logic        alarm_en_q, alarm_en_d;
  logic        alarm_active_q, alarm_active_d;
  logic        phase_q, phase_d;
  logic        match_q, match;
  logic [3:0]  strobe_q, strobe_d;  // {min_inc, min_dec, hr_inc, hr_dec}
  logic        any_btn;

  function automatic logic [12:0] min_step(input logic [12:0] t, input logic up);
    logic [2:0] tens;
    logic [3:0] ones;
    tens = t[6:4];
    ones = t[3:0];
    if (up) begin
      if (ones == 4'd9) begin
        ones = 4'd0;
        tens = (tens == 3'd5) ? 3'd0 : tens + 3'd1;
      end else ones = ones + 4'd1;
    end else begin
      if (ones == 4'd0) begin
        ones = 4'd9;
        tens = (tens == 3'd0) ? 3'd5 : tens - 3'd1;
      end else ones = ones - 4'd1;
    end
    return {t[12:7], tens, ones};
  endfunction

  function automatic logic [12:0] hr_step(input logic [12:0] t, input logic up);
    logic [1:0] tens;
    logic [3:0] ones;
    tens = t[12:11];
    ones = t[10:7];
    if (up) begin
      if (tens == 2'd2 && ones == 4'd3) begin
        tens = 2'd0;
        ones = 4'd0;
      end else if (ones == 4'd9) begin
        ones = 4'd0;
        tens = tens + 2'd1;
      end else ones = ones + 4'd1;
    end else begin
      if (tens == 2'd0 && ones == 4'd0) begin
        tens = 2'd2;
        ones = 4'd3;
      end else if (ones == 4'd0) begin
        ones = 4'd9;
        tens = tens - 2'd1;
      end else ones = ones - 4'd1;
    end
    return {tens, ones, t[6:0]};
  endfunction

  assign match   = (cur_time == alarm_time_q);
  assign any_btn = btnc | btnr | btnl | btnu | btnd;

  always_comb begin
    state_d        = state_q;
    alarm_time_d   = alarm_time_q;
    alarm_en_d     = alarm_en_q;
    alarm_active_d = alarm_active_q;
    strobe_d       = 4'b0000;
    // A ringing alarm swallows the first button pulse as the acknowledge.
    if (alarm_active_q && any_btn) begin
      alarm_active_d = 1'b0;
    end else begin
      if (state_q == S_CLOCK && alarm_en_q && match && !match_q) alarm_active_d = 1'b1;
      if (btnc) begin
        state_d = (state_q == S_CLOCK) ? S_CLK_MIN : S_CLOCK;
      end else if (btnr) begin
        case (state_q)
          S_CLK_MIN: state_d = S_CLK_HR;
          S_CLK_HR:  state_d = S_ALM_MIN;
          S_ALM_MIN: state_d = S_ALM_HR;
          S_ALM_HR:  state_d = S_CLK_MIN;
          default:   state_d = state_q;
        endcase
      end else if (btnl) begin
        case (state_q)
          S_CLK_MIN: state_d = S_ALM_HR;
          S_CLK_HR:  state_d = S_CLK_MIN;
          S_ALM_MIN: state_d = S_CLK_HR;
          S_ALM_HR:  state_d = S_ALM_MIN;
          default:   state_d = state_q;
        endcase
      end else if (btnu || btnd) begin
        case (state_q)
          S_CLOCK:   alarm_en_d   = btnu ? ~alarm_en_q : alarm_en_q;
          S_CLK_MIN: strobe_d     = btnu ? 4'b1000 : 4'b0100;
          S_CLK_HR:  strobe_d     = btnu ? 4'b0010 : 4'b0001;
          S_ALM_MIN: alarm_time_d = min_step(alarm_time_q, btnu);
          S_ALM_HR:  alarm_time_d = hr_step(alarm_time_q, btnu);
          default:   strobe_d     = 4'b0000;
        endcase
      end
    end
    if (state_d != state_q) phase_d = 1'b0;
    else if (tick_1hz)      phase_d = ~phase_q;
    else                    phase_d = phase_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_CLOCK;
      alarm_time_q   <= 13'd0;
      alarm_en_q     <= 1'b0;
      alarm_active_q <= 1'b0;
      phase_q        <= 1'b0;
      match_q        <= 1'b1;
      strobe_q       <= 4'b0000;
    end else begin
      state_q        <= state_d;
      alarm_time_q   <= alarm_time_d;
      alarm_en_q     <= alarm_en_d;
      alarm_active_q <= alarm_active_d;
      phase_q        <= phase_d;
      match_q        <= match;
      strobe_q       <= strobe_d;
    end
  end

  assign {min_inc, min_dec, hr_inc, hr_dec} = strobe_q;
  assign alarm_time   = alarm_time_q;
  assign alarm_en     = alarm_en_q;
  assign alarm_active = alarm_active_q;
  assign clk_run      = !(state_q == S_CLK_MIN || state_q == S_CLK_HR);
  assign disp_alarm   = (state_q == S_ALM_MIN || state_q == S_ALM_HR);
  assign mode_led     = 5'b00001 << state_q;
  assign blink_mask   = (BLINK_EN && phase_q && state_q != S_CLOCK)
                        ? ((state_q == S_CLK_MIN || state_q == S_ALM_MIN) ? 4'b0011 : 4'b1100)
                        : 4'b0000;

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Bench for alarm_clock_ctrl: directed test-plan steps followed by random button
// traffic, compared each cycle against a decimal-arithmetic reference model.
module tb_alarm_clock_ctrl;

  logic        clk, reset, tick_1hz;
  logic        btnc, btnr, btnl, btnu, btnd;
  logic [12:0] cur_time;
  logic        clk_run, min_inc, min_dec, hr_inc, hr_dec;
  logic [12:0] alarm_time;
  logic        disp_alarm, alarm_en, alarm_active;
  logic [3:0]  blink_mask;
  logic [4:0]  mode_led;

  int checks = 0;
  int errors = 0;

  alarm_clock_ctrl #(.BLINK_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .btnc(btnc), .btnr(btnr), .btnl(btnl), .btnu(btnu), .btnd(btnd),
    .cur_time(cur_time), .clk_run(clk_run),
    .min_inc(min_inc), .min_dec(min_dec), .hr_inc(hr_inc), .hr_dec(hr_dec),
    .alarm_time(alarm_time), .disp_alarm(disp_alarm), .blink_mask(blink_mask),
    .alarm_en(alarm_en), .alarm_active(alarm_active), .mode_led(mode_led)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: mode 0 = CLOCK, 1..4 = CLK_MIN, CLK_HR, ALM_MIN, ALM_HR ring
  int       m_mode, m_hr, m_min;
  bit       m_en, m_act, m_phase, m_match_q;
  bit [3:0] m_strobe;  // {min_inc, min_dec, hr_inc, hr_dec}

  localparam logic [4:0] B_C = 5'b10000, B_R = 5'b01000, B_L = 5'b00100,
                         B_U = 5'b00010, B_D = 5'b00001, B_0 = 5'b00000;

  function automatic logic [12:0] to_bcd(input int h, input int m);
    logic [1:0] ht;
    logic [3:0] ho;
    logic [2:0] mt;
    logic [3:0] mo;
    ht = 2'(h / 10); ho = 4'(h % 10);
    mt = 3'(m / 10); mo = 4'(m % 10);
    return {ht, ho, mt, mo};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_hr = 0; m_min = 0;
    m_en = 0; m_act = 0; m_phase = 0; m_match_q = 1; m_strobe = 4'b0000;
  endtask

  task automatic model_step(input logic [4:0] b, input bit t);
    bit match;
    int nmode;
    match    = (cur_time == to_bcd(m_hr, m_min));
    nmode    = m_mode;
    m_strobe = 4'b0000;
    if (m_act && b != 5'b0) begin
      m_act = 0;
    end else begin
      if (m_mode == 0 && m_en && match && !m_match_q) m_act = 1;
      if (b[4]) nmode = (m_mode == 0) ? 1 : 0;
      else if (b[3]) begin
        if (m_mode != 0) nmode = m_mode % 4 + 1;
      end else if (b[2]) begin
        if (m_mode != 0) nmode = (m_mode + 2) % 4 + 1;
      end else if (b[1] || b[0]) begin
        case (m_mode)
          0: if (b[1]) m_en = !m_en;
          1: m_strobe = b[1] ? 4'b1000 : 4'b0100;
          2: m_strobe = b[1] ? 4'b0010 : 4'b0001;
          3: m_min = b[1] ? (m_min + 1) % 60 : (m_min + 59) % 60;
          default: m_hr = b[1] ? (m_hr + 1) % 24 : (m_hr + 23) % 24;
        endcase
      end
    end
    if (nmode != m_mode) m_phase = 0;
    else if (t) m_phase = !m_phase;
    m_mode    = nmode;
    m_match_q = match;
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] exp_blink;
    exp_blink = 4'b0000;
    if (m_mode != 0 && m_phase) exp_blink = (m_mode == 1 || m_mode == 3) ? 4'b0011 : 4'b1100;
    chk({tag, ":mode_led"}, 13'(mode_led), 13'(5'b00001 << m_mode));
    chk({tag, ":clk_run"}, 13'(clk_run), 13'(!(m_mode == 1 || m_mode == 2)));
    chk({tag, ":disp_alarm"}, 13'(disp_alarm), 13'(m_mode == 3 || m_mode == 4));
    chk({tag, ":blink"}, 13'(blink_mask), 13'(exp_blink));
    chk({tag, ":alarm_time"}, alarm_time, to_bcd(m_hr, m_min));
    chk({tag, ":alarm_en"}, 13'(alarm_en), 13'(m_en));
    chk({tag, ":alarm_active"}, 13'(alarm_active), 13'(m_act));
    chk({tag, ":strobes"}, 13'({min_inc, min_dec, hr_inc, hr_dec}), 13'(m_strobe));
  endtask

  // driver: inputs applied just after a rising edge, outputs checked 1 time unit after the next
  task automatic step(input string tag, input logic [4:0] b, input bit t);
    {btnc, btnr, btnl, btnu, btnd} = b;
    tick_1hz = t;
    model_step(b, t);
    @(posedge clk);
    #1;
    {btnc, btnr, btnl, btnu, btnd} = 5'b0;
    tick_1hz = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_all("reset");
  endtask

  initial begin
    reset = 1'b1; tick_1hz = 1'b0;
    {btnc, btnr, btnl, btnu, btnd} = 5'b0;
    cur_time = to_bcd(12, 0);
    do_reset();

    // mode ring walk
    step("walk_c", B_C, 0);
    step("walk_r1", B_R, 0);
    step("walk_r2", B_R, 0);
    step("walk_r3", B_R, 0);
    step("walk_r4", B_R, 0);
    step("walk_l", B_L, 0);
    chk("walk_l_is_alm_hr", 13'(mode_led), 13'(5'b10000));
    step("walk_c2", B_C, 0);
    chk("walk_back_clock", 13'(mode_led), 13'(5'b00001));

    // alarm minute / hour wraps
    step("nav_c", B_C, 0);
    step("nav_r", B_R, 0);
    step("nav_r", B_R, 0);
    step("min_dec_wrap", B_D, 0);
    chk("alm_0059", alarm_time, to_bcd(0, 59));
    step("min_inc_wrap", B_U, 0);
    chk("alm_0000", alarm_time, to_bcd(0, 0));
    step("min_dec_wrap2", B_D, 0);
    step("to_hr", B_R, 0);
    step("hr_dec_wrap", B_D, 0);
    chk("alm_2359", alarm_time, to_bcd(23, 59));
    step("hr_inc_wrap", B_U, 0);
    chk("alm_0059b", alarm_time, to_bcd(0, 59));
    for (int i = 0; i < 5; i++) step("hr_down", B_D, 0);
    chk("alm_1959", alarm_time, to_bcd(19, 59));
    step("hr_19_20", B_U, 0);
    chk("alm_2059", alarm_time, to_bcd(20, 59));

    // clock-hour strobes and button priority
    step("to_clk_min", B_R, 0);
    step("to_clk_hr", B_R, 0);
    step("hr_inc_pulse", B_U, 0);
    chk("hr_inc_high", 13'(hr_inc), 13'd1);
    step("hr_inc_idle", B_0, 0);
    chk("hr_inc_low", 13'(hr_inc), 13'd0);
    step("hr_dec_pulse", B_D, 0);
    step("prio_r_over_u", B_R | B_U, 0);
    chk("prio_alm_min", 13'(mode_led), 13'(5'b01000));
    step("prio_c_over_all", 5'b11111, 0);

    // alarm firing at 07:30
    do_reset();
    step("set_c", B_C, 0);
    step("set_r", B_R, 0);
    step("set_r", B_R, 0);
    for (int i = 0; i < 30; i++) step("set_min", B_U, 0);
    step("set_r", B_R, 0);
    for (int i = 0; i < 7; i++) step("set_hr", B_U, 0);
    chk("alm_0730", alarm_time, to_bcd(7, 30));
    step("set_c", B_C, 0);
    step("arm", B_U, 0);
    cur_time = to_bcd(7, 29);
    step("pre_match", B_0, 0);
    cur_time = to_bcd(7, 30);
    step("match_edge", B_0, 0);
    chk("alarm_fired", 13'(alarm_active), 13'd1);
    step("ringing", B_0, 0);
    step("ack_btnd", B_D, 0);
    chk("ack_cleared", 13'(alarm_active), 13'd0);
    chk("ack_en_kept", 13'(alarm_en), 13'd1);
    for (int i = 0; i < 4; i++) step("no_refire", B_0, 0);

    // disarmed: no fire; re-entering CLOCK at a match: no fire
    step("disarm", B_U, 0);
    cur_time = to_bcd(7, 29);
    step("dis_pre", B_0, 0);
    cur_time = to_bcd(7, 30);
    step("dis_match", B_0, 0);
    chk("dis_no_fire", 13'(alarm_active), 13'd0);
    step("rearm", B_U, 0);
    step("adj_in", B_C, 0);
    step("adj_out", B_C, 0);
    step("adj_hold", B_0, 0);
    chk("return_no_fire", 13'(alarm_active), 13'd0);

    // blink and async reset
    step("blk_c", B_C, 0);
    step("blk_l", B_L, 0);
    step("blink_on", B_0, 1);
    chk("blink_1100", 13'(blink_mask), 13'(4'b1100));
    step("blink_off", B_0, 1);
    chk("blink_0000", 13'(blink_mask), 13'd0);
    step("blink_on2", B_0, 1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      logic [4:0] b;
      int sel;
      for (int k = 0; k < 5; k++) b[k] = ($urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 3);
      if (sel == 0) cur_time = to_bcd(m_hr, m_min);
      else if (sel >= 2) cur_time = to_bcd($urandom_range(0, 23), $urandom_range(0, 59));
      step("rand", b, $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
